// File: rtl/mips_multicycle_ctrl_fsm_if.sv
// ============================================================================
//  Module   : mips_multicycle_ctrl_fsm_if
//  Brief    : Controller <-> datapath signal bundle for the multicycle MIPS core
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_multicycle_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_write, ir_write, pc_write, branch, iord, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_write, ir_write, pc_write, branch, iord, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_fsm.sv
// ============================================================================
//  Module   : mips_multicycle_ctrl_fsm
//  Brief    : Main control FSM of the multicycle MIPS datapath (Moore outputs)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl_fsm #(
  parameter bit WAIT_ON_MEM = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_ctrl_fsm_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    ANDIEX  = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;
  logic   ready;

  assign ready     = WAIT_ON_MEM ? bus.mem_ready : 1'b1;
  assign bus.state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_src     = 2'b00;
    bus.illegal_op = 1'b0;

    case (state_q)
      FETCH: begin
        // PC+4 and IR load only commit once the instruction word is valid
        bus.alu_src_b = 2'b01;
        bus.ir_write  = ready;
        bus.pc_write  = ready;
        state_d       = ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d        = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        state_d  = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        state_d       = ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = ALUWB;
      end
      ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        bus.branch    = 1'b1;
        state_d       = FETCH;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = IMMWB;
      end
      ANDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        state_d       = IMMWB;
      end
      IMMWB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl_fsm.sv
// ============================================================================
//  Module   : tb_mips_multicycle_ctrl_fsm
//  Brief    : Directed vector bench for the multicycle MIPS control FSM
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl_fsm;

  logic clk;
  logic rst_n;

  mips_multicycle_ctrl_fsm_if bus ();

  mips_multicycle_ctrl_fsm #(.WAIT_ON_MEM(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_write, ir_write, pc_write, branch, iord, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], illegal_op}
  localparam logic [15:0] O_FETCH_R = 16'b0_1_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] O_FETCH_N = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] O_DEC     = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] O_DEC_ILL = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [15:0] O_MEMADR  = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] O_MEMRD   = 16'b0_0_0_0_1_0_0_0_0_00_00_00_0;
  localparam logic [15:0] O_MEMWB   = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] O_MEMWR   = 16'b1_0_0_0_1_0_0_0_0_00_00_00_0;
  localparam logic [15:0] O_EXEC    = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] O_ALUWB   = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] O_BRANCH  = 16'b0_0_0_1_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] O_ADDIEX  = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] O_ANDIEX  = 16'b0_0_0_0_0_0_0_0_1_10_11_00_0;
  localparam logic [15:0] O_IMMWB   = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] O_JUMP    = 16'b0_0_1_0_0_0_0_0_0_00_00_10_0;

  typedef struct {
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_fail;

  function automatic logic [15:0] outs();
    return {bus.mem_write, bus.ir_write, bus.pc_write, bus.branch, bus.iord,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_cycle(input string name, input logic [3:0] exp_state, input logic [15:0] exp_out);
    check({name, ".state"}, {12'd0, bus.state}, {12'd0, exp_state});
    check({name, ".outs"}, outs(), exp_out);
    if (bus.reg_write && bus.mem_write) begin
      n_fail++;
      $display("FAIL %s.rw_excl: reg_write=1 mem_write=1 required not both", name);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st, input logic [15:0] o);
    vec_t v;
    v.opcode = op; v.mem_ready = rdy; v.exp_state = st; v.exp_out = o;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    // lw, no stall: 0,1,2,3,4
    add(6'h23, 1, 0, O_FETCH_R); add(6'h23, 1, 1, O_DEC); add(6'h23, 1, 2, O_MEMADR);
    add(6'h23, 1, 3, O_MEMRD);   add(6'h23, 1, 4, O_MEMWB);
    // lw with one stall in FETCH and one in MEMRD
    add(6'h23, 0, 0, O_FETCH_N); add(6'h23, 1, 0, O_FETCH_R); add(6'h23, 1, 1, O_DEC);
    add(6'h23, 1, 2, O_MEMADR);  add(6'h23, 0, 3, O_MEMRD);   add(6'h23, 1, 3, O_MEMRD);
    add(6'h23, 1, 4, O_MEMWB);
    // sw with two stall cycles in MEMWR
    add(6'h2B, 1, 0, O_FETCH_R); add(6'h2B, 1, 1, O_DEC);   add(6'h2B, 1, 2, O_MEMADR);
    add(6'h2B, 0, 5, O_MEMWR);   add(6'h2B, 0, 5, O_MEMWR); add(6'h2B, 1, 5, O_MEMWR);
    // R-type then beq
    add(6'h00, 1, 0, O_FETCH_R); add(6'h00, 1, 1, O_DEC); add(6'h00, 1, 6, O_EXEC);
    add(6'h00, 1, 7, O_ALUWB);
    add(6'h04, 1, 0, O_FETCH_R); add(6'h04, 1, 1, O_DEC); add(6'h04, 1, 8, O_BRANCH);
    // andi then addi
    add(6'h0C, 1, 0, O_FETCH_R); add(6'h0C, 1, 1, O_DEC); add(6'h0C, 1, 12, O_ANDIEX);
    add(6'h0C, 1, 10, O_IMMWB);
    add(6'h08, 1, 0, O_FETCH_R); add(6'h08, 1, 1, O_DEC); add(6'h08, 1, 9, O_ADDIEX);
    add(6'h08, 1, 10, O_IMMWB);
    // jump then illegal opcode, which must return straight to FETCH
    add(6'h02, 1, 0, O_FETCH_R); add(6'h02, 1, 1, O_DEC); add(6'h02, 1, 11, O_JUMP);
    add(6'h3F, 1, 0, O_FETCH_R); add(6'h3F, 1, 1, O_DEC_ILL);
    add(6'h3F, 1, 0, O_FETCH_R); add(6'h3F, 1, 1, O_DEC_ILL);

    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_cycle("reset_nrdy", 4'd0, O_FETCH_N);
    bus.mem_ready = 1'b1;
    #1 check_cycle("reset_rdy", 4'd0, O_FETCH_R);

    @(negedge clk);
    check_cycle("reset_hold", 4'd0, O_FETCH_R);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.opcode    = vecs[i].opcode;
      bus.mem_ready = vecs[i].mem_ready;
      #1 check_cycle($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_out);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of EXECUTE
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b1;
    #1 check_cycle("ar_fetch", 4'd0, O_FETCH_R);
    @(negedge clk);
    @(negedge clk);
    #1 check_cycle("ar_exec", 4'd6, O_EXEC);
    #1 rst_n = 1'b0;
    #1 check_cycle("ar_async", 4'd0, O_FETCH_R);
    @(negedge clk);
    #1 check_cycle("ar_held", 4'd0, O_FETCH_R);
    rst_n = 1'b1;
    #1 check_cycle("ar_release", 4'd0, O_FETCH_R);
    @(negedge clk);
    #1 check_cycle("ar_decode", 4'd1, O_DEC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl_fsm.md
Name: mips_multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath. Sits directly upstream of the ALU function decoder.
- Decodes the 6-bit opcode over several cycles and sequences fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp that the ALU decoder consumes, plus all datapath enables and mux selects.
- Supports a memory-ready handshake so fetch and memory cycles can stretch.

Parameters:
- WAIT_ON_MEM, 1: when 1, FETCH/MEMRD/MEMWR hold until mem_ready=1. When 0, mem_ready is ignored and is treated as 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26], taken from the instruction register
- mem_ready  in  1  memory access completes this cycle
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register load
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load; the datapath ANDs it with the zero flag
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- reg_dst  out  1  write-register select: 0=rt, 1=rd
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- alu_op  out  2  to the ALU decoder: 00=add, 01=sub, 10=funct, 11=and
- pc_src  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug and verification

Behaviour:
- Fixed state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, IMMWB=10, JUMP=11, ANDIEX=12. Encodings 13–15 are unused and go to FETCH on the next edge.
- Reset: rst_n=0 forces state=FETCH immediately (asynchronous), mid-instruction included. Outputs are Moore, decoded from state, so reset drives them to FETCH values with ir_write/pc_write gated by mem_ready. illegal_op=0.
- Defaults: every output not listed for a state is 0.
- Per-state outputs:
  - FETCH: alu_src_b=01, alu_op=00, pc_src=00, iord=0. ir_write=pc_write=mem_ready (the only Mealy gating). Stays in FETCH while mem_ready=0.
  - DECODE: alu_src_b=11, alu_op=00. Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 001100 -> ANDIEX; 000010 -> JUMP. Any other opcode -> FETCH with illegal_op=1 for this cycle only.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD, sw -> MEMWR. The opcode is re-sampled here; the IR is stable.
  - MEMRD: iord=1. Holds until mem_ready, then -> MEMWB.
  - MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1. -> FETCH.
  - MEMWR: iord=1, mem_write=1 held until mem_ready, then -> FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
  - ALUWB: reg_dst=1, reg_write=1. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. -> IMMWB.
  - ANDIEX: same as ADDIEX but alu_op=11. -> IMMWB.
  - IMMWB: reg_dst=0, reg_write=1. -> FETCH.
  - JUMP: pc_src=10, pc_write=1. -> FETCH.
- Cycle counts with mem_ready held at 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi/andi: 4
  - beq: 3
  - j: 3
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- reg_write and mem_write are never both asserted in the same cycle.

Test Plan:
- Reset: assert rst_n=0 mid-EXECUTE -> state=0 immediately, with no clock edge; after release and mem_ready=1, ir_write=pc_write=1 and alu_src_b=01.
- lw: opcode=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. In state 4, reg_write=1, mem_to_reg=1, reg_dst=0.
- sw with stall: opcode=101011, mem_ready=0 for 2 cycles in MEMWR -> mem_write=1 for 3 cycles; state sequence 0,1,2,5,5,5,0. reg_write stays 0 throughout.
- R-type then beq: opcode=000000 -> alu_op=10 in state 6, then reg_dst=1, reg_write=1 in state 7. Next opcode=000100 -> state 8 with alu_op=01, pc_src=01, branch=1.
- andi vs addi: opcode=001100 -> state 12 with alu_op=11. Opcode=001000 -> state 9 with alu_op=00. Both then go to state 10 with reg_write=1, reg_dst=0.
- Jump and illegal: opcode=000010 -> state 11 with pc_src=10, pc_write=1. Opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH with no reg_write and no mem_write.
